// File: rtl/mux_scan_pkg.sv
// Shared constants for the channel scanner: FSM state encodings and mode values.
// States are plain 2-bit constants so older code that compares raw values keeps working.
package mux_scan_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_OFF  = 2'd0;
   localparam state_t ST_MAN  = 2'd1;
   localparam state_t ST_SCAN = 2'd2;

   localparam logic MODE_MAN  = 1'b0;
   localparam logic MODE_SCAN = 1'b1;

endpackage

// File: rtl/mux_scan_n_dec.sv
// SW-to-NCH one-hot decoder with enable; indices at or beyond NCH decode to all-zero.
module dec_n #(
   parameter int NCH = 8,
   parameter int SW  = $clog2(NCH)
) (
   input  logic          en,
   input  logic [SW-1:0] idx,
   output logic [NCH-1:0] onehot
);

   always_comb begin
      onehot = '0;
      for (int k = 0; k < NCH; k++) begin
         if (en && (idx == SW'(k))) onehot[k] = 1'b1;
      end
   end

endmodule

// File: rtl/mux_scan_n.sv
// N-channel mux with manual select and auto-scan; every output is registered, one cycle latency.
// Scan dwells dwell+1 cycles per channel and pulses wrap when it returns from NCH-1 to 0.
module mux_scan_n
   import mux_scan_pkg::*;
#(
   parameter int NCH     = 8,
   parameter int W       = 8,
   parameter int DWELL_W = 8,
   localparam int SW     = $clog2(NCH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               n_en,
   input  logic               mode,
   input  logic [SW-1:0]      sel,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [NCH*W-1:0]   din,
   output logic [W-1:0]       dout,
   output logic [SW-1:0]      ch_idx,
   output logic [NCH-1:0]     ch_onehot,
   output logic               valid,
   output logic               wrap
);

   localparam int SW1 = SW + 1;
   localparam logic [SW:0]   NCH_L = SW1'(NCH);
   localparam logic [SW-1:0] LAST  = SW'(NCH - 1);

   state_t             state_q, state_d;
   logic [SW-1:0]      ptr_q, ptr_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [SW-1:0]      idx_d;
   logic               valid_d, wrap_d, sel_ok;
   logic [W-1:0]       dout_d;
   logic [NCH-1:0]     onehot_d;

   // The pointer is only meaningful while scanning; any other state clears it so re-entry restarts.
   always_comb begin
      state_d = ST_OFF;
      ptr_d   = '0;
      cnt_d   = '0;
      idx_d   = '0;
      valid_d = 1'b0;
      wrap_d  = 1'b0;
      sel_ok  = ({1'b0, sel} < NCH_L);
      if (!n_en) begin
         if (mode == MODE_MAN) begin
            state_d = ST_MAN;
            idx_d   = sel;
            valid_d = sel_ok;
         end else begin
            state_d = ST_SCAN;
            if (state_q != ST_SCAN) begin
               ptr_d = (state_q == ST_MAN && sel_ok) ? sel : '0;
               cnt_d = dwell;
            end else if (cnt_q == '0) begin
               ptr_d  = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
               cnt_d  = dwell;
               wrap_d = (ptr_q == LAST);
            end else begin
               ptr_d = ptr_q;
               cnt_d = cnt_q - 1'b1;
            end
            idx_d   = ptr_d;
            valid_d = 1'b1;
         end
      end
   end

   always_comb begin
      dout_d = '0;
      for (int k = 0; k < NCH; k++) begin
         if (valid_d && (idx_d == SW'(k))) dout_d = din[k*W +: W];
      end
   end

   dec_n #(.NCH(NCH), .SW(SW)) u_dec (
      .en     (valid_d),
      .idx    (idx_d),
      .onehot (onehot_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_OFF;
         ptr_q     <= '0;
         cnt_q     <= '0;
         dout      <= '0;
         ch_idx    <= '0;
         ch_onehot <= '0;
         valid     <= 1'b0;
         wrap      <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         dout      <= dout_d;
         ch_idx    <= idx_d;
         ch_onehot <= onehot_d;
         valid     <= valid_d;
         wrap      <= wrap_d;
      end
   end

endmodule

// File: tb/tb_mux_scan_n.sv
// Bench for mux_scan_n: an 8-channel and a 6-channel instance share one control stream.
// Expected outputs are queued as stimulus is applied and popped one cycle later.
module tb_mux_scan_n;

   logic        clk = 1'b0;
   logic        rst_n, n_en, mode;
   logic [2:0]  sel;
   logic [7:0]  dwell;
   logic [63:0] din;

   logic [7:0] dout8, oh8;
   logic [2:0] idx8;
   logic       valid8, wrap8;
   logic [7:0] dout6;
   logic [5:0] oh6;
   logic [2:0] idx6;
   logic       valid6, wrap6;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [2:0] idx;
      logic       valid;
      logic       wrap;
      logic [7:0] dout;
      logic [7:0] onehot;
   } exp_t;

   typedef struct {
      logic       ne;
      logic       md;
      logic [2:0] s;
      logic [7:0] dw;
      logic [2:0] e_idx;
      logic       e_valid;
      logic       e_wrap;
   } vec_t;

   exp_t sb_q[$];
   vec_t man_tab[8];

   mux_scan_n #(.NCH(8), .W(8), .DWELL_W(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .n_en(n_en), .mode(mode), .sel(sel), .dwell(dwell),
      .din(din), .dout(dout8), .ch_idx(idx8), .ch_onehot(oh8), .valid(valid8), .wrap(wrap8)
   );

   mux_scan_n #(.NCH(6), .W(8), .DWELL_W(8)) dut6 (
      .clk(clk), .rst_n(rst_n), .n_en(n_en), .mode(mode), .sel(sel), .dwell(dwell),
      .din(din[47:0]), .dout(dout6), .ch_idx(idx6), .ch_onehot(oh6), .valid(valid6), .wrap(wrap6)
   );

   always #5 clk = ~clk;

   function automatic exp_t make_exp(input logic [2:0] i, input logic v, input logic w);
      exp_t e;
      e.idx    = v ? i : (i & 3'd0);
      e.valid  = v;
      e.wrap   = w;
      e.dout   = v ? (8'h10 + 8'(i)) : 8'h00;
      e.onehot = v ? (8'b1 << i) : 8'h00;
      return e;
   endfunction

   task automatic check_output(input string name);
      exp_t e;
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $display("[TB] FAIL %s: scoreboard empty", name);
      end else begin
         e = sb_q.pop_front();
         if ({idx8, valid8, wrap8, dout8, oh8} !== {e.idx, e.valid, e.wrap, e.dout, e.onehot}) begin
            errors++;
            $display("[TB] FAIL %s: got idx=%0d valid=%b wrap=%b dout=%h oh=%b, expected idx=%0d valid=%b wrap=%b dout=%h oh=%b",
                     name, idx8, valid8, wrap8, dout8, oh8, e.idx, e.valid, e.wrap, e.dout, e.onehot);
         end
      end
   endtask

   task automatic check6(input string name, input logic [2:0] ei, input logic ev, input logic ew);
      logic [7:0] ed;
      logic [5:0] eo;
      ed = ev ? (8'h10 + 8'(ei)) : 8'h00;
      eo = ev ? (6'b1 << ei) : 6'b0;
      checks++;
      if ({idx6, valid6, wrap6, dout6, oh6} !== {ei, ev, ew, ed, eo}) begin
         errors++;
         $display("[TB] FAIL %s: got idx=%0d valid=%b wrap=%b dout=%h oh=%b, expected idx=%0d valid=%b wrap=%b dout=%h oh=%b",
                  name, idx6, valid6, wrap6, dout6, oh6, ei, ev, ew, ed, eo);
      end
   endtask

   task automatic apply_stimulus(input logic ne, input logic md, input logic [2:0] s,
                                 input logic [7:0] dw, input logic [2:0] ei,
                                 input logic ev, input logic ew, input string name);
      n_en  = ne;
      mode  = md;
      sel   = s;
      dwell = dw;
      sb_q.push_back(make_exp(ei, ev, ew));
      @(posedge clk);
      #1;
      check_output(name);
   endtask

   initial begin
      for (int k = 0; k < 8; k++) din[k*8 +: 8] = 8'h10 + 8'(k);
      for (int i = 0; i < 8; i++) man_tab[i] = '{1'b0, 1'b0, 3'(i), 8'd0, 3'(i), 1'b1, 1'b0};

      rst_n = 1'b0; n_en = 1'b1; mode = 1'b0; sel = 3'd0; dwell = 8'd0;
      #1;
      sb_q.push_back(make_exp(3'd0, 1'b0, 1'b0));
      check_output("reset_state");
      #2 rst_n = 1'b1;
      apply_stimulus(1'b1, 1'b0, 3'd3, 8'd0, 3'd0, 1'b0, 1'b0, "disabled");

      // Manual sweep from the table
      for (int i = 0; i < 8; i++)
         apply_stimulus(man_tab[i].ne, man_tab[i].md, man_tab[i].s, man_tab[i].dw,
                        man_tab[i].e_idx, man_tab[i].e_valid, man_tab[i].e_wrap,
                        $sformatf("manual_sel%0d", i));

      // Scan from OFF with dwell=2: three cycles per channel, wrap on the return to 0
      apply_stimulus(1'b1, 1'b1, 3'd3, 8'd2, 3'd0, 1'b0, 1'b0, "off_before_scan");
      for (int c = 0; c < 8; c++)
         for (int r = 0; r < 3; r++)
            apply_stimulus(1'b0, 1'b1, 3'd3, 8'd2, 3'(c), 1'b1, 1'b0,
                           $sformatf("scan_d2_ch%0d_r%0d", c, r));
      apply_stimulus(1'b0, 1'b1, 3'd3, 8'd2, 3'd0, 1'b1, 1'b1, "scan_d2_wrap");

      // dwell dropped to 0 mid-channel only takes effect at the next reload
      apply_stimulus(1'b0, 1'b1, 3'd3, 8'd0, 3'd0, 1'b1, 1'b0, "dwell_chg_hold1");
      apply_stimulus(1'b0, 1'b1, 3'd3, 8'd0, 3'd0, 1'b1, 1'b0, "dwell_chg_hold2");
      apply_stimulus(1'b0, 1'b1, 3'd3, 8'd0, 3'd1, 1'b1, 1'b0, "dwell0_ch1");
      apply_stimulus(1'b0, 1'b1, 3'd3, 8'd0, 3'd2, 1'b1, 1'b0, "dwell0_ch2");
      apply_stimulus(1'b0, 1'b1, 3'd3, 8'd0, 3'd3, 1'b1, 1'b0, "dwell0_ch3");

      // Manual sel=5 then scan: start at 5, sel ignored afterwards
      apply_stimulus(1'b0, 1'b0, 3'd5, 8'd0, 3'd5, 1'b1, 1'b0, "man5");
      apply_stimulus(1'b0, 1'b1, 3'd5, 8'd0, 3'd5, 1'b1, 1'b0, "scan_from5");
      apply_stimulus(1'b0, 1'b1, 3'd2, 8'd0, 3'd6, 1'b1, 1'b0, "scan_ch6");
      apply_stimulus(1'b0, 1'b1, 3'd2, 8'd0, 3'd7, 1'b1, 1'b0, "scan_ch7");
      apply_stimulus(1'b0, 1'b1, 3'd2, 8'd0, 3'd0, 1'b1, 1'b1, "scan_wrap_from5");
      apply_stimulus(1'b0, 1'b1, 3'd2, 8'd0, 3'd1, 1'b1, 1'b0, "scan_ch1");
      for (int c = 2; c <= 4; c++)
         apply_stimulus(1'b0, 1'b1, 3'd2, 8'd0, 3'(c), 1'b1, 1'b0, $sformatf("scan_to_ch%0d", c));

      // One disabled cycle at ch 4 restarts the scan at 0
      apply_stimulus(1'b1, 1'b1, 3'd2, 8'd0, 3'd0, 1'b0, 1'b0, "glitch_off");
      apply_stimulus(1'b0, 1'b1, 3'd2, 8'd0, 3'd0, 1'b1, 1'b0, "restart_ch0");
      apply_stimulus(1'b0, 1'b1, 3'd2, 8'd0, 3'd1, 1'b1, 1'b0, "restart_ch1");
      apply_stimulus(1'b0, 1'b1, 3'd2, 8'd0, 3'd2, 1'b1, 1'b0, "restart_ch2");

      // Asynchronous reset between edges
      #2 rst_n = 1'b0;
      #1;
      sb_q.push_back(make_exp(3'd0, 1'b0, 1'b0));
      check_output("async_reset");
      @(posedge clk);
      #1;
      sb_q.push_back(make_exp(3'd0, 1'b0, 1'b0));
      check_output("reset_held");
      rst_n = 1'b1;
      apply_stimulus(1'b0, 1'b1, 3'd2, 8'd0, 3'd0, 1'b1, 1'b0, "post_reset_ch0");
      apply_stimulus(1'b0, 1'b1, 3'd2, 8'd0, 3'd1, 1'b1, 1'b0, "post_reset_ch1");

      // Six-channel instance: out-of-range select and 5 -> 0 wrap
      apply_stimulus(1'b0, 1'b0, 3'd6, 8'd0, 3'd6, 1'b1, 1'b0, "man6_n8");
      check6("n6_man_sel6", 3'd6, 1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b0, 3'd7, 8'd0, 3'd7, 1'b1, 1'b0, "man7_n8");
      check6("n6_man_sel7", 3'd7, 1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b1, 3'd7, 8'd0, 3'd7, 1'b1, 1'b0, "scan_from7_n8");
      check6("n6_scan_start0", 3'd0, 1'b1, 1'b0);
      apply_stimulus(1'b0, 1'b1, 3'd7, 8'd0, 3'd0, 1'b1, 1'b1, "n8_wrap_b");
      check6("n6_scan_ch1", 3'd1, 1'b1, 1'b0);
      for (int c = 2; c <= 5; c++) begin
         apply_stimulus(1'b0, 1'b1, 3'd7, 8'd0, 3'(c - 1), 1'b1, 1'b0, $sformatf("n8_ch%0d", c - 1));
         check6($sformatf("n6_scan_ch%0d", c), 3'(c), 1'b1, 1'b0);
      end
      apply_stimulus(1'b0, 1'b1, 3'd7, 8'd0, 3'd5, 1'b1, 1'b0, "n8_ch5");
      check6("n6_wrap", 3'd0, 1'b1, 1'b1);
      apply_stimulus(1'b0, 1'b1, 3'd7, 8'd0, 3'd6, 1'b1, 1'b0, "n8_ch6");
      check6("n6_after_wrap", 3'd1, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
